// File: rtl/ring_counter_multimode.sv
// Multimode shift-register sequencer: one-hot ring or Johnson (twisted-ring)
// sequences with run/hold, direction, parallel load, phase index, wrap pulse
// and a sticky error flag for illegal states, which are replaced by the seed.
module ring_counter_multimode #(
   parameter int WIDTH     = 8,
   parameter int RESET_POS = WIDTH - 1,
   parameter int PW        = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear_err,
   output logic [WIDTH-1:0] q,
   output logic [PW-1:0]    phase,
   output logic             wrap,
   output logic             err
);

   typedef enum logic {
      MODE_RING    = 1'b0,
      MODE_JOHNSON = 1'b1
   } mode_t;

   localparam logic [WIDTH-1:0] RING_SEED    = WIDTH'(1) << RESET_POS;
   localparam logic [WIDTH-1:0] JOHNSON_SEED = '0;
   localparam logic [PW-1:0]    LAST_RING    = PW'(WIDTH - 1);
   localparam logic [PW-1:0]    LAST_JOHNSON = PW'(2 * WIDTH - 1);

   mode_t            mode_q, mode_n;
   logic [WIDTH-1:0] q_n;
   logic [PW-1:0]    phase_n;
   logic             wrap_n;
   logic             err_n;
   logic             err_set;
   logic [PW-1:0]    last_phase;

   function automatic int popcount(input logic [WIDTH-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   // Johnson states have at most one boundary between adjacent bits:
   // ones-then-zeros from the MSB, zeros-then-ones, all zeros or all ones.
   function automatic logic is_legal(input logic [WIDTH-1:0] v, input mode_t m);
      int edges;
      edges = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (v[i] != v[i+1]) edges++;
      end
      if (m == MODE_RING) return (popcount(v) == 1);
      return (edges <= 1);
   endfunction

   function automatic logic [WIDTH-1:0] seed_of(input mode_t m);
      return (m == MODE_RING) ? RING_SEED : JOHNSON_SEED;
   endfunction

   // Phase of a legal state: ring counts steps of the hot bit away from
   // RESET_POS toward the LSB; Johnson counts fill (MSB side) then drain.
   function automatic logic [PW-1:0] phase_of(input logic [WIDTH-1:0] v, input mode_t m);
      int idx;
      idx = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) idx = i;
      end
      if (m == MODE_RING) return PW'((RESET_POS - idx + WIDTH) % WIDTH);
      if (v == '0) return '0;
      if (v[WIDTH-1]) return PW'(popcount(v));
      return PW'(2 * WIDTH - popcount(v));
   endfunction

   assign last_phase = (mode_q == MODE_RING) ? LAST_RING : LAST_JOHNSON;

   // Next-state selection: mode change, then load, then step, then hold.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      q_n     = q;
      phase_n = phase;
      wrap_n  = 1'b0;
      mode_n  = mode_q;
      err_set = 1'b0;

      if (mode_t'(mode) != mode_q) begin
         mode_n  = mode_t'(mode);
         q_n     = seed_of(mode_t'(mode));
         phase_n = '0;
      end else if (load) begin
         if (is_legal(load_val, mode_q)) begin
            q_n     = load_val;
            phase_n = phase_of(load_val, mode_q);
         end else begin
            q_n     = seed_of(mode_q);
            phase_n = '0;
            err_set = 1'b1;
         end
      end else if (en) begin
         if (!is_legal(q, mode_q)) begin
            // Upset state: resynchronise to the seed instead of shifting garbage.
            q_n     = seed_of(mode_q);
            phase_n = '0;
            err_set = 1'b1;
         end else begin
            if (mode_q == MODE_RING) begin
               q_n = dir ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
            end else begin
               q_n = dir ? {q[WIDTH-2:0], ~q[WIDTH-1]} : {~q[0], q[WIDTH-1:1]};
            end
            if (!dir) begin
               wrap_n  = (phase == last_phase);
               phase_n = (phase == last_phase) ? '0 : phase + PW'(1);
            end else begin
               wrap_n  = (phase == '0);
               phase_n = (phase == '0) ? last_phase : phase - PW'(1);
            end
         end
      end

      // A new error beats a simultaneous clear.
      err_n = err_set ? 1'b1 : (clear_err ? 1'b0 : err);
   end

   // State register with asynchronous active-high reset to the ring seed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values together.
         q      <= RING_SEED;
         phase  <= '0;
         wrap   <= 1'b0;
         err    <= 1'b0;
         mode_q <= MODE_RING;
      end else begin
         q      <= q_n;
         phase  <= phase_n;
         wrap   <= wrap_n;
         err    <= err_n;
         mode_q <= mode_n;
      end
   end

endmodule
